// File: rtl/id_stage_pipe.sv
// -----------------------------------------------------------------------------
// id_stage_pipe
//
// Decode stage of the five-stage RV32I pipeline. Holds the architectural
// register file, builds sign-extended immediates, resolves operand hazards
// against EX/MEM/WB and registers everything into the ID/EX pipeline register.
//
// Build option:
//   ID_FWD_EN defined   : EX and MEM forwarding into the operands; only a
//                         load in EX stalls (one cycle).
//   ID_FWD_EN undefined : no EX/MEM forwarding; any pending EX or MEM write to
//                         a used source stalls until the value reaches WB
//                         (picked up through the register-file WB bypass).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_valid/if_inst/if_pc   IF/ID register contents
//   ctrl_*                   decoder controls for the instruction in ID
//   ex_fwd_data              ALU result of the instruction now in ID/EX
//   mem_we/mem_rd/mem_fwd_data  MEM-stage write-back info
//   wb_we/wb_rd/wb_data      register-file write port
//   flush                    redirect, kills the instruction in ID
//   id_stall                 hold PC and IF/ID this cycle
//   ex_*                     ID/EX pipeline register outputs
// -----------------------------------------------------------------------------
module id_stage_pipe #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            if_valid,
    input  logic [31:0]     if_inst,
    input  logic [XLEN-1:0] if_pc,

    input  logic [2:0]      ctrl_sext_op,
    input  logic            ctrl_rf_we,
    input  logic [1:0]      ctrl_wd_sel,
    input  logic            ctrl_mem_rd,
    input  logic            ctrl_use_rs1,
    input  logic            ctrl_use_rs2,

    input  logic [XLEN-1:0] ex_fwd_data,
    input  logic            mem_we,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,

    output logic            id_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [AW-1:0]   ex_rd,
    output logic            ex_rf_we,
    output logic [1:0]      ex_wd_sel,
    output logic            ex_mem_rd
);

    localparam logic [2:0] SEXT_I = 3'd0;
    localparam logic [2:0] SEXT_S = 3'd1;
    localparam logic [2:0] SEXT_B = 3'd2;
    localparam logic [2:0] SEXT_U = 3'd3;
    localparam logic [2:0] SEXT_J = 3'd4;

    // -------------------------------------------------------------------------
    // Instruction fields
    // -------------------------------------------------------------------------
    logic [AW-1:0] rs1_a;
    logic [AW-1:0] rs2_a;
    logic [AW-1:0] rd_a;

    assign rs1_a = if_inst[15 +: AW];
    assign rs2_a = if_inst[20 +: AW];
    assign rd_a  = if_inst[7 +: AW];

    // A source only matters when the instruction reads it and it is not x0.
    logic use1_live;
    logic use2_live;

    assign use1_live = ctrl_use_rs1 && (rs1_a != '0);
    assign use2_live = ctrl_use_rs2 && (rs2_a != '0);

    // -------------------------------------------------------------------------
    // Register file: two async read ports, one write port, x0 hard-wired.
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] rf [NREG];
    logic            wb_live;

    assign wb_live = wb_we && (wb_rd != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_live) begin
            rf[wb_rd] <= wb_data;
        end
    end

    // Write-first: a WB write in the same cycle is visible to the ID read.
    logic [XLEN-1:0] rf_rd1;
    logic [XLEN-1:0] rf_rd2;

    always_comb begin
        rf_rd1 = rf[rs1_a];
        if (rs1_a == '0) begin
            rf_rd1 = '0;
        end else if (wb_live && (wb_rd == rs1_a)) begin
            rf_rd1 = wb_data;
        end
    end

    always_comb begin
        rf_rd2 = rf[rs2_a];
        if (rs2_a == '0) begin
            rf_rd2 = '0;
        end else if (wb_live && (wb_rd == rs2_a)) begin
            rf_rd2 = wb_data;
        end
    end

    // -------------------------------------------------------------------------
    // Immediate generation (built at 32 bits, then sign-extended to XLEN)
    // -------------------------------------------------------------------------
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext;

    always_comb begin
        imm32 = '0;
        case (ctrl_sext_op)
            SEXT_I:  imm32 = {{20{if_inst[31]}}, if_inst[31:20]};
            SEXT_S:  imm32 = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
            SEXT_B:  imm32 = {{19{if_inst[31]}}, if_inst[31], if_inst[7],
                              if_inst[30:25], if_inst[11:8], 1'b0};
            SEXT_U:  imm32 = {if_inst[31:12], 12'b0};
            SEXT_J:  imm32 = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12],
                              if_inst[20], if_inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm_ext = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

    // -------------------------------------------------------------------------
    // Operand selection and hazard detection
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            hazard;

`ifdef ID_FWD_EN
    // A load in EX has no data yet, so it is excluded from the EX bypass and
    // handled by the one-cycle load-use stall instead.
    logic ex_fwd_ok;
    logic ex_hit1;
    logic ex_hit2;
    logic mem_hit1;
    logic mem_hit2;
    logic ld_in_ex;

    assign ex_fwd_ok = ex_valid && ex_rf_we && !ex_mem_rd;
    assign ex_hit1   = use1_live && ex_fwd_ok && (ex_rd == rs1_a);
    assign ex_hit2   = use2_live && ex_fwd_ok && (ex_rd == rs2_a);
    assign mem_hit1  = use1_live && mem_we && (mem_rd == rs1_a);
    assign mem_hit2  = use2_live && mem_we && (mem_rd == rs2_a);

    always_comb begin
        op1 = rf_rd1;
        if (ex_hit1) begin
            op1 = ex_fwd_data;
        end else if (mem_hit1) begin
            op1 = mem_fwd_data;
        end
    end

    always_comb begin
        op2 = rf_rd2;
        if (ex_hit2) begin
            op2 = ex_fwd_data;
        end else if (mem_hit2) begin
            op2 = mem_fwd_data;
        end
    end

    assign ld_in_ex = ex_valid && ex_mem_rd && ex_rf_we && (ex_rd != '0);
    assign hazard   = ld_in_ex &&
                      ((use1_live && (ex_rd == rs1_a)) ||
                       (use2_live && (ex_rd == rs2_a)));

    logic unused_sink;
    assign unused_sink = ^{if_inst[6:0]};
`else
    // Without bypass paths the consumer waits until the producer reaches WB,
    // where the register-file bypass delivers the value.
    logic ex_wr;
    logic mem_wr;

    assign ex_wr  = ex_valid && ex_rf_we && (ex_rd != '0);
    assign mem_wr = mem_we && (mem_rd != '0);

    assign op1 = rf_rd1;
    assign op2 = rf_rd2;

    assign hazard = (use1_live && ((ex_wr  && (ex_rd  == rs1_a)) ||
                                   (mem_wr && (mem_rd == rs1_a)))) ||
                    (use2_live && ((ex_wr  && (ex_rd  == rs2_a)) ||
                                   (mem_wr && (mem_rd == rs2_a))));

    logic unused_sink;
    assign unused_sink = ^{if_inst[6:0], ex_fwd_data, mem_fwd_data};
`endif

    // A redirect kills the instruction anyway, so it never needs to stall.
    assign id_stall = if_valid && hazard && !flush;

    // -------------------------------------------------------------------------
    // ID/EX pipeline register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_rf_we    <= 1'b0;
            ex_wd_sel   <= '0;
            ex_mem_rd   <= 1'b0;
        end else if (flush || id_stall) begin
            // Bubble: only the qualifying bits matter, data fields hold.
            ex_valid  <= 1'b0;
            ex_rf_we  <= 1'b0;
            ex_mem_rd <= 1'b0;
        end else begin
            ex_valid    <= if_valid;
            ex_pc       <= if_pc;
            ex_rs1_data <= op1;
            ex_rs2_data <= op2;
            ex_imm      <= imm_ext;
            ex_rd       <= rd_a;
            ex_rf_we    <= if_valid && ctrl_rf_we;
            ex_wd_sel   <= ctrl_wd_sel;
            ex_mem_rd   <= if_valid && ctrl_mem_rd;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// -----------------------------------------------------------------------------
// tb_id_stage_pipe
//
// Directed scoreboard bench for id_stage_pipe. Each cycle the expected ID/EX
// contents are pushed when the stimulus is driven and popped/compared one
// edge later. The surrounding pipeline (EX result, MEM, WB) is modelled by
// driving those ports directly. Build with or without ID_FWD_EN.
// -----------------------------------------------------------------------------
module tb_id_stage_pipe;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [2:0]  ctrl_sext_op;
    logic        ctrl_rf_we;
    logic [1:0]  ctrl_wd_sel;
    logic        ctrl_mem_rd;
    logic        ctrl_use_rs1;
    logic        ctrl_use_rs2;
    logic [31:0] ex_fwd_data;
    logic        mem_we;
    logic [4:0]  mem_rd;
    logic [31:0] mem_fwd_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        id_stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_rf_we;
    logic [1:0]  ex_wd_sel;
    logic        ex_mem_rd;

    id_stage_pipe #(.XLEN(32), .NREG(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_valid     (if_valid),
        .if_inst      (if_inst),
        .if_pc        (if_pc),
        .ctrl_sext_op (ctrl_sext_op),
        .ctrl_rf_we   (ctrl_rf_we),
        .ctrl_wd_sel  (ctrl_wd_sel),
        .ctrl_mem_rd  (ctrl_mem_rd),
        .ctrl_use_rs1 (ctrl_use_rs1),
        .ctrl_use_rs2 (ctrl_use_rs2),
        .ex_fwd_data  (ex_fwd_data),
        .mem_we       (mem_we),
        .mem_rd       (mem_rd),
        .mem_fwd_data (mem_fwd_data),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .flush        (flush),
        .id_stall     (id_stall),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_rs1_data  (ex_rs1_data),
        .ex_rs2_data  (ex_rs2_data),
        .ex_imm       (ex_imm),
        .ex_rd        (ex_rd),
        .ex_rf_we     (ex_rf_we),
        .ex_wd_sel    (ex_wd_sel),
        .ex_mem_rd    (ex_mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        full;
        logic        valid;
        logic        rf_we;
        logic        mem_rd;
        logic [1:0]  wd_sel;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
    } exp_t;

    exp_t  sb[$];
    string tq[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t bub();
        exp_t e;
        e = '0;
        return e;
    endfunction

    function automatic exp_t zero_all();
        exp_t e;
        e = '0;
        e.full = 1'b1;
        return e;
    endfunction

    function automatic exp_t cap(input logic [31:0] pc, input logic [31:0] r1,
                                 input logic [31:0] r2, input logic [31:0] imm,
                                 input logic [4:0] rd, input logic we,
                                 input logic [1:0] ws, input logic mr);
        exp_t e;
        e.full   = 1'b1;
        e.valid  = 1'b1;
        e.rf_we  = we;
        e.mem_rd = mr;
        e.wd_sel = ws;
        e.rd     = rd;
        e.pc     = pc;
        e.rs1    = r1;
        e.rs2    = r2;
        e.imm    = imm;
        return e;
    endfunction

    function automatic logic [31:0] r_ins(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
    endfunction

    function automatic logic [31:0] i_ins(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [11:0] imm, input logic [2:0] f3,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    task automatic tick();
        exp_t  e;
        string t;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            t = tq.pop_front();
            chk({t, "/valid"},  32'(ex_valid),  32'(e.valid));
            chk({t, "/rf_we"},  32'(ex_rf_we),  32'(e.rf_we));
            chk({t, "/mem_rd"}, 32'(ex_mem_rd), 32'(e.mem_rd));
            if (e.full) begin
                chk({t, "/pc"},     ex_pc,            e.pc);
                chk({t, "/rs1"},    ex_rs1_data,      e.rs1);
                chk({t, "/rs2"},    ex_rs2_data,      e.rs2);
                chk({t, "/imm"},    ex_imm,           e.imm);
                chk({t, "/rd"},     32'(ex_rd),       32'(e.rd));
                chk({t, "/wd_sel"}, 32'(ex_wd_sel),   32'(e.wd_sel));
            end
        end
    endtask

    task automatic step(input string tag, input logic stall_exp, input exp_t e);
        #1;
        chk({tag, "/stall"}, 32'(id_stall), 32'(stall_exp));
        sb.push_back(e);
        tq.push_back(tag);
        tick();
    endtask

    task automatic op(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic [2:0] sop, input logic we, input logic [1:0] ws,
                      input logic mr, input logic u1, input logic u2);
        if_valid     = v;
        if_inst      = inst;
        if_pc        = pc;
        ctrl_sext_op = sop;
        ctrl_rf_we   = we;
        ctrl_wd_sel  = ws;
        ctrl_mem_rd  = mr;
        ctrl_use_rs1 = u1;
        ctrl_use_rs2 = u2;
    endtask

    task automatic env(input logic [31:0] exd, input logic mwe, input logic [4:0] mrd,
                       input logic [31:0] md, input logic wwe, input logic [4:0] wrd,
                       input logic [31:0] wd, input logic fl);
        ex_fwd_data  = exd;
        mem_we       = mwe;
        mem_rd       = mrd;
        mem_fwd_data = md;
        wb_we        = wwe;
        wb_rd        = wrd;
        wb_data      = wd;
        flush        = fl;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] add_x5_x4;
        logic [31:0] lw_x4;
        add_x5_x4 = r_ins(5'd5, 5'd4, 5'd0);
        lw_x4     = i_ins(5'd4, 5'd0, 12'd0, 3'b010, 7'h03);

        rst = 1'b1;
        op(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        env(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        step("rst0", 1'b0, zero_all());
        step("rst1", 1'b0, zero_all());
        rst = 1'b0;

        // Fresh register file reads zero.
        op(1'b1, r_ins(5'd3, 5'd1, 5'd2), 32'h100, 3'd5, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1);
        step("add_after_rst", 1'b0, cap(32'h100, 32'h0, 32'h0, 32'h0, 5'd3, 1'b1, 2'd0, 1'b0));

        // WB bypass into the same-cycle read.
        op(1'b1, r_ins(5'd6, 5'd5, 5'd0), 32'h104, 3'd5, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1);
        env(32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h1234, 1'b0);
        step("wb_bypass", 1'b0, cap(32'h104, 32'h1234, 32'h0, 32'h0, 5'd6, 1'b1, 2'd2, 1'b0));

        // Write to x0 is dropped; x5 now comes from the array.
        op(1'b1, r_ins(5'd7, 5'd0, 5'd5), 32'h108, 3'd5, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1);
        env(32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        step("x0_wb", 1'b0, cap(32'h108, 32'h0, 32'h1234, 32'h0, 5'd7, 1'b1, 2'd0, 1'b0));

        op(1'b1, r_ins(5'd8, 5'd0, 5'd5), 32'h10C, 3'd5, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1);
        env(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        step("x0_later", 1'b0, cap(32'h10C, 32'h0, 32'h1234, 32'h0, 5'd8, 1'b1, 2'd0, 1'b0));

        // Invalid slot forces the write/load qualifiers low.
        op(1'b0, r_ins(5'd9, 5'd0, 5'd0), 32'h110, 3'd5, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
        step("idle_force", 1'b0, bub());

        // Producer ADDI x1,x0,7.
        op(1'b1, i_ins(5'd1, 5'd0, 12'd7, 3'd0, 7'h13), 32'h200, 3'd0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
        step("addi_x1", 1'b0, cap(32'h200, 32'h0, 32'h0, 32'h7, 5'd1, 1'b1, 2'd0, 1'b0));

        op(1'b1, r_ins(5'd2, 5'd1, 5'd1), 32'h204, 3'd5, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1);
        env(32'h7, 1'b1, 5'd1, 32'h9, 1'b0, 5'd0, 32'h0, 1'b0);
`ifdef ID_FWD_EN
        step("ex_prio", 1'b0, cap(32'h204, 32'h7, 32'h7, 32'h0, 5'd2, 1'b1, 2'd0, 1'b0));
        op(1'b1, r_ins(5'd9, 5'd1, 5'd0), 32'h208, 3'd5, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1);
        env(32'h55, 1'b1, 5'd1, 32'h9, 1'b0, 5'd0, 32'h0, 1'b0);
        step("mem_fwd", 1'b0, cap(32'h208, 32'h9, 32'h0, 32'h0, 5'd9, 1'b1, 2'd0, 1'b0));
`else
        step("raw_ex_s1", 1'b1, bub());
        env(32'h0, 1'b1, 5'd1, 32'h7, 1'b0, 5'd0, 32'h0, 1'b0);
        step("raw_ex_s2", 1'b1, bub());
        env(32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 32'h7, 1'b0);
        step("raw_wb", 1'b0, cap(32'h204, 32'h7, 32'h7, 32'h0, 5'd2, 1'b1, 2'd0, 1'b0));
`endif

        op(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        env(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        step("idle1", 1'b0, bub());

        // Load-use.
        op(1'b1, lw_x4, 32'h300, 3'd0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
        step("lw_x4", 1'b0, cap(32'h300, 32'h0, 32'h0, 32'h0, 5'd4, 1'b1, 2'd1, 1'b1));
        op(1'b1, add_x5_x4, 32'h304, 3'd5, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1);
        step("ld_use_stall", 1'b1, bub());
        env(32'h0, 1'b1, 5'd4, 32'hABCD, 1'b0, 5'd0, 32'h0, 1'b0);
`ifdef ID_FWD_EN
        step("ld_use_fwd", 1'b0, cap(32'h304, 32'hABCD, 32'h0, 32'h0, 5'd5, 1'b1, 2'd0, 1'b0));
`else
        step("ld_use_mem", 1'b1, bub());
        env(32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'hABCD, 1'b0);
        step("ld_use_wb", 1'b0, cap(32'h304, 32'hABCD, 32'h0, 32'h0, 5'd5, 1'b1, 2'd0, 1'b0));
`endif

        op(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        env(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        step("idle2", 1'b0, bub());

        // Flush beats the load-use hazard.
        op(1'b1, lw_x4, 32'h400, 3'd0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
        step("lw_x4_b", 1'b0, cap(32'h400, 32'h0, 32'h0, 32'h0, 5'd4, 1'b1, 2'd1, 1'b1));
        op(1'b1, add_x5_x4, 32'h404, 3'd5, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1);
        flush = 1'b1;
        step("flush_hazard", 1'b0, bub());
        op(1'b1, r_ins(5'd10, 5'd0, 5'd0), 32'h408, 3'd5, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1);
        step("flush_plain", 1'b0, bub());
        flush = 1'b0;

        // Reset during a stall clears everything, including the register file.
        op(1'b1, lw_x4, 32'h500, 3'd0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
        step("lw_x4_c", 1'b0, cap(32'h500, 32'h0, 32'h0, 32'h0, 5'd4, 1'b1, 2'd1, 1'b1));
        op(1'b1, add_x5_x4, 32'h504, 3'd5, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        step("rst_in_stall", 1'b1, zero_all());
        rst = 1'b0;
        op(1'b1, r_ins(5'd11, 5'd5, 5'd1), 32'h600, 3'd5, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1);
        step("rf_cleared", 1'b0, cap(32'h600, 32'h0, 32'h0, 32'h0, 5'd11, 1'b1, 2'd0, 1'b0));

        // Immediate formats.
        op(1'b1, 32'hFE00_0FE3, 32'h700, 3'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        step("imm_b", 1'b0, cap(32'h700, 32'h0, 32'h0, 32'hFFFF_FFFE, 5'd31, 1'b0, 2'd0, 1'b0));
        op(1'b1, 32'h8000_00B7, 32'h704, 3'd3, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        step("imm_u", 1'b0, cap(32'h704, 32'h0, 32'h0, 32'h8000_0000, 5'd1, 1'b1, 2'd0, 1'b0));
        op(1'b1, 32'h7FFF_F06F, 32'h708, 3'd4, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        step("imm_j", 1'b0, cap(32'h708, 32'h0, 32'h0, 32'h000F_FFFE, 5'd0, 1'b1, 2'd0, 1'b0));
        op(1'b1, {7'h7F, 5'd1, 5'd2, 3'b010, 5'h18, 7'h23}, 32'h70C, 3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        step("imm_s", 1'b0, cap(32'h70C, 32'h0, 32'h0, 32'hFFFF_FFF8, 5'd24, 1'b0, 2'd0, 1'b0));
        op(1'b1, i_ins(5'd3, 5'd0, 12'h800, 3'd0, 7'h13), 32'h710, 3'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        step("imm_i", 1'b0, cap(32'h710, 32'h0, 32'h0, 32'hFFFF_F800, 5'd3, 1'b1, 2'd0, 1'b0));
        op(1'b1, 32'hFFFF_FFFF, 32'h714, 3'd7, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
        step("imm_other", 1'b0, cap(32'h714, 32'h0, 32'h0, 32'h0, 5'd31, 1'b0, 2'd3, 1'b0));

        op(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        step("idle_end", 1'b0, bub());

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
